ddr4_cmd_data_driver: RTL
=========================

DDR4_CMD_DATA_DRIVER -- requirements
Module: ddr4_cmd_data_driver

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DQ_WIDTH, 8, DQ pins per device.
- DQS_WIDTH, 1, DQS pins.
- BURST_LEN, 8, beats per RD/WR.
- CWL, tCWL, write latency in clk.
- CL, tCL, read latency in clk.
- ROW_WIDTH, 14, row/ADDR bits.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 sole clock, rising edge.
- reset in 1 synchronous, active-high.
- cmd_valid in 1 command offered.
- cmd_ready out 1 command accepted this cycle when valid&ready.
- command in 3 CMD_NOP/ACT/PRE/RD/WR/PREA.
- address in 32 controller-encoded address.
- auto_pre in 1 A10 for RD/WR.
- write_data in BURST_LEN*DQ_WIDTH burst; beat0 in LSBs.
- CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14 out 1 each DDR4 control pins.
- BG out 2; BA out 2; ADDR out ROW_WIDTH.
- dq_en out 1; dq_out out DQ_WIDTH; dqs_en out 1; dqs_out out DQS_WIDTH.
- dq_in in DQ_WIDTH read data from DRAM.
- rd_data out BURST_LEN*DQ_WIDTH assembled read burst, beat0 in LSBs.
- rd_valid out 1 one-cycle read-burst strobe.
- busy out 1 any data beat pending.

Function
REQ-003 Pin outputs SHALL be registered; a command accepted at cycle T SHALL appear on pins at T+1 (pin cycle C) for exactly one cycle, then NOP (CS_n=0, ACT_n/RAS/CAS/WE=1).
REQ-004 Encoding SHALL be ACT: ACT_n=0, ADDR=row, RAS/CAS/WE=row[13:11]; PRE: RAS=0,CAS=1,WE=0, A10=0; PREA: as PRE with A10=1; RD: CAS=0,WE=1; WR: CAS=0,WE=0; RD/WR ADDR[9:0]=column, ADDR[10]=auto_pre, others 0.
REQ-005 Accepting cmd_valid with CMD_NOP SHALL leave pins at NOP; unknown codes SHALL be treated as NOP.
REQ-006 Write beats SHALL drive on cycles C+CWL .. C+CWL+BURST_LEN-1, one beat per clk, beat k = write_data slice k captured at T; dq_en=1 exactly on those cycles.
REQ-007 dqs_en SHALL assert one preamble cycle before beat 0 (dqs_out=0) through the last beat; dqs_out SHALL be 1 on even beats, 0 on odd beats.
REQ-008 Read beats SHALL be sampled from dq_in on cycles C+CL .. C+CL+BURST_LEN-1; rd_data SHALL update and rd_valid pulse for one cycle on the cycle after the last beat.
REQ-009 Write validity SHALL be tracked by valid bits, never by data value; all-zero write data SHALL still drive the bus.
REQ-010 ACT/PRE/PREA/NOP SHALL always be ready; RD/WR SHALL be ready only when cycles since last accepted RD/WR >= gap G: WR->WR and RD->RD G=BURST_LEN; WR->RD G=CWL+BURST_LEN+1-CL (min 1); RD->WR G=CL+BURST_LEN+1-CWL. The since-counter SHALL saturate and SHALL be ready after reset.
REQ-011 cmd_ready MAY depend combinationally on command; it SHALL NOT depend on cmd_valid.
REQ-012 busy SHALL be 1 from the cycle after accepting RD/WR until rd_valid or the last write beat completes.

Reset
REQ-013 During reset: CKE=1, CS_n=1, ACT_n/RAS/CAS/WE=1, BG=BA=ADDR=0, dq_en=dqs_en=0, dq_out=dqs_out=0, rd_data=0, rd_valid=0, busy=0, cmd_ready=0.
REQ-014 Reset mid-burst SHALL discard all pending write/read beats; no beat or rd_valid SHALL appear after reset deasserts.

Structure
REQ-015 CMD_* codes (PREA=3'd5), tCL, tCWL and address field MSB/LSB constants SHALL live in the shared dram_timings package.
REQ-016 Write serialisation plus DQS generation SHALL be one sub-module, ddr4_wr_burst_shifter; read capture and turnaround gating stay in the top module.

Verification (CWL=9, CL=11, BURST_LEN=8, DQ_WIDTH=8)
REQ-017 WR at T, BG=1 BA=2 col=0x3C, data=0x0706050403020100 -> pins CAS=0 WE=0 ADDR=0x03C at T+1; dq_out 00..07 on T+10..T+17; dqs_en from T+9.
REQ-018 WR with write_data=0 -> dq_en=1 for 8 cycles, dq_out=0.
REQ-019 WR at T then RD offered continuously -> cmd_ready=0 until T+7, RD accepted at T+7; RD then WR -> WR accepted at T+11.
REQ-020 RD auto_pre=1 col=0x10, dq_in=0xA0+k on beat k -> ADDR=0x410; rd_valid at C+19 with rd_data=0xA7A6..A0.
REQ-021 PREA -> RAS=0 CAS=1 WE=0 ADDR[10]=1; ACT row=0x2ABC -> ACT_n=0 ADDR=0x2ABC.
REQ-022 reset asserted at beat 3 of a write -> dq_en=0 next cycle, busy=0, no rd_valid afterwards.

Source files
------------

// File: rtl/ddr4_cmd_data_driver_pkg.sv
// dram_timings: command codes, DDR4 latencies and controller address field layout.
package dram_timings;
    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_PRE  = 3'd2,
        CMD_RD   = 3'd3,
        CMD_WR   = 3'd4,
        CMD_PREA = 3'd5
    } cmd_e;
    localparam int tCL  = 11;
    localparam int tCWL = 9;
    localparam int COL_LSB = 0;
    localparam int COL_MSB = 9;
    localparam int ROW_LSB = 10;
    localparam int ROW_MSB = 23;
    localparam int BA_LSB  = 24;
    localparam int BA_MSB  = 25;
    localparam int BG_LSB  = 26;
    localparam int BG_MSB  = 27;
endpackage

// File: rtl/ddr4_wr_burst_shifter.sv
// ddr4_wr_burst_shifter: schedules write beats CWL cycles out and serialises them with DQS.
module ddr4_wr_burst_shifter #(
    parameter int DQ_WIDTH  = 8,
    parameter int DQS_WIDTH = 1,
    parameter int BURST_LEN = 8,
    parameter int CWL       = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [BURST_LEN*DQ_WIDTH-1:0] data,
    output logic                          dq_en,
    output logic [DQ_WIDTH-1:0]           dq_out,
    output logic                          dqs_en,
    output logic [DQS_WIDTH-1:0]          dqs_out,
    output logic                          busy
);
    localparam int N = CWL + BURST_LEN;
    // Slot j drives the pins j cycles after load; beat k lands in slot CWL+k, preamble in CWL-1.
    localparam logic [N-1:0] BEAT_MASK = {{BURST_LEN{1'b1}}, {CWL{1'b0}}};
    localparam logic [N-1:0] DQS_MASK  = BEAT_MASK | (BEAT_MASK >> 1);
    localparam logic [N-1:0] DQS_PAT   = {{(BURST_LEN / 2){2'b01}}, {CWL{1'b0}}};

    logic [N-1:0]          vld_q, vld_d, den_q, den_d, dqs_q, dqs_d;
    logic [N*DQ_WIDTH-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = (vld_q >> 1) | (load ? BEAT_MASK : '0);
        den_d = (den_q >> 1) | (load ? DQS_MASK : '0);
        dqs_d = (dqs_q >> 1) | (load ? DQS_PAT : '0);
        dat_d = (dat_q >> DQ_WIDTH) | (load ? {data, {(CWL * DQ_WIDTH){1'b0}}} : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            den_q <= '0;
            dqs_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            den_q <= den_d;
            dqs_q <= dqs_d;
            dat_q <= dat_d;
        end
    end

    assign dq_en   = vld_q[0];
    assign dq_out  = dat_q[DQ_WIDTH-1:0];
    assign dqs_en  = den_q[0];
    assign dqs_out = {DQS_WIDTH{dqs_q[0]}};
    assign busy    = |vld_q;
endmodule

// File: rtl/ddr4_cmd_data_driver.sv
// ddr4_cmd_data_driver: registers DDR4 command pins, enforces RD/WR turnaround,
// drives write bursts and assembles read bursts.
module ddr4_cmd_data_driver import dram_timings::*; #(
    parameter int DQ_WIDTH  = 8,
    parameter int DQS_WIDTH = 1,
    parameter int BURST_LEN = 8,
    parameter int CWL       = tCWL,
    parameter int CL        = tCL,
    parameter int ROW_WIDTH = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    command,
    input  logic [31:0]                   address,
    input  logic                          auto_pre,
    input  logic [BURST_LEN*DQ_WIDTH-1:0] write_data,
    output logic                          CKE,
    output logic                          CS_n,
    output logic                          ACT_n,
    output logic                          RAS_n_A16,
    output logic                          CAS_n_A15,
    output logic                          WE_n_A14,
    output logic [1:0]                    BG,
    output logic [1:0]                    BA,
    output logic [ROW_WIDTH-1:0]          ADDR,
    output logic                          dq_en,
    output logic [DQ_WIDTH-1:0]           dq_out,
    output logic                          dqs_en,
    output logic [DQS_WIDTH-1:0]          dqs_out,
    input  logic [DQ_WIDTH-1:0]           dq_in,
    output logic [BURST_LEN*DQ_WIDTH-1:0] rd_data,
    output logic                          rd_valid,
    output logic                          busy
);
    localparam int BW        = BURST_LEN * DQ_WIDTH;
    localparam int RN        = CL + BURST_LEN;
    localparam int WR_RD_RAW = CWL + BURST_LEN + 1 - CL;
    localparam int RD_WR_RAW = CL + BURST_LEN + 1 - CWL;
    localparam logic [7:0] G_SAME  = 8'(BURST_LEN);
    localparam logic [7:0] G_WR_RD = 8'(WR_RD_RAW < 1 ? 1 : WR_RD_RAW);
    localparam logic [7:0] G_RD_WR = 8'(RD_WR_RAW < 1 ? 1 : RD_WR_RAW);
    localparam logic [RN-1:0] RD_MASK = {{BURST_LEN{1'b1}}, {CL{1'b0}}};
    localparam logic [RN-1:0] RD_LAST = {1'b1, {(RN - 1){1'b0}}};

    logic                 is_rd, is_wr, accept, wr_busy, unused_addr;
    logic [7:0]           gap, since_q, since_d;
    logic                 last_wr_q, last_wr_d;
    logic                 cs_n_q, cs_n_d, act_n_q, act_n_d, ras_q, ras_d, cas_q, cas_d, we_q, we_d;
    logic [1:0]           bg_q, bg_d, ba_q, ba_d;
    logic [ROW_WIDTH-1:0] addr_q, addr_d, row;
    logic [RN-1:0]        rvld_q, rvld_d, rlast_q, rlast_d;
    logic [BW-1:0]        asm_q, asm_d, rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    assign is_rd       = command == CMD_RD;
    assign is_wr       = command == CMD_WR;
    // Required spacing depends on the previous RD/WR direction and the one now offered.
    assign gap         = is_rd ? (last_wr_q ? G_WR_RD : G_SAME) : (last_wr_q ? G_SAME : G_RD_WR);
    assign cmd_ready   = !reset && (!(is_rd || is_wr) || since_q >= gap);
    assign accept      = cmd_valid && cmd_ready;
    assign row         = address[ROW_LSB +: ROW_WIDTH];
    assign unused_addr = ^address[31:BG_MSB+1];

    always_comb begin
        cs_n_d  = 1'b0;
        act_n_d = 1'b1;
        ras_d   = 1'b1;
        cas_d   = 1'b1;
        we_d    = 1'b1;
        bg_d    = '0;
        ba_d    = '0;
        addr_d  = '0;
        if (accept) begin
            if (command inside {CMD_ACT, CMD_PRE, CMD_RD, CMD_WR}) begin
                bg_d = address[BG_MSB:BG_LSB];
                ba_d = address[BA_MSB:BA_LSB];
            end
            case (command)
                CMD_ACT: begin
                    act_n_d               = 1'b0;
                    addr_d                = row;
                    {ras_d, cas_d, we_d}  = row[ROW_WIDTH-1 -: 3];
                end
                CMD_PRE, CMD_PREA: begin
                    ras_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d[10] = command == CMD_PREA;
                end
                CMD_RD, CMD_WR: begin
                    cas_d       = 1'b0;
                    we_d        = is_rd;
                    addr_d[10]  = auto_pre;
                    addr_d[9:0] = address[COL_MSB:COL_LSB];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        since_d    = (accept && (is_rd || is_wr)) ? 8'd1 : (since_q == 8'hFF ? since_q : since_q + 8'd1);
        last_wr_d  = (accept && (is_rd || is_wr)) ? is_wr : last_wr_q;
        rvld_d     = (rvld_q >> 1) | ((accept && is_rd) ? RD_MASK : '0);
        rlast_d    = (rlast_q >> 1) | ((accept && is_rd) ? RD_LAST : '0);
        asm_d      = rvld_q[0] ? {dq_in, asm_q[BW-1:DQ_WIDTH]} : asm_q;
        rd_valid_d = rvld_q[0] && rlast_q[0];
        rd_data_d  = rd_valid_d ? asm_d : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_q     <= 1'b1;
            act_n_q    <= 1'b1;
            ras_q      <= 1'b1;
            cas_q      <= 1'b1;
            we_q       <= 1'b1;
            bg_q       <= '0;
            ba_q       <= '0;
            addr_q     <= '0;
            since_q    <= 8'hFF;
            last_wr_q  <= 1'b0;
            rvld_q     <= '0;
            rlast_q    <= '0;
            asm_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cs_n_q     <= cs_n_d;
            act_n_q    <= act_n_d;
            ras_q      <= ras_d;
            cas_q      <= cas_d;
            we_q       <= we_d;
            bg_q       <= bg_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            since_q    <= since_d;
            last_wr_q  <= last_wr_d;
            rvld_q     <= rvld_d;
            rlast_q    <= rlast_d;
            asm_q      <= asm_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    ddr4_wr_burst_shifter #(
        .DQ_WIDTH (DQ_WIDTH),
        .DQS_WIDTH(DQS_WIDTH),
        .BURST_LEN(BURST_LEN),
        .CWL      (CWL)
    ) u_wr (
        .clk    (clk),
        .reset  (reset),
        .load   (accept && is_wr),
        .data   (write_data),
        .dq_en  (dq_en),
        .dq_out (dq_out),
        .dqs_en (dqs_en),
        .dqs_out(dqs_out),
        .busy   (wr_busy)
    );

    assign CKE       = 1'b1;
    assign CS_n      = cs_n_q;
    assign ACT_n     = act_n_q;
    assign RAS_n_A16 = ras_q;
    assign CAS_n_A15 = cas_q;
    assign WE_n_A14  = we_q;
    assign BG        = bg_q;
    assign BA        = ba_q;
    assign ADDR      = addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = wr_busy || |rvld_q;
endmodule
